// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// and front-end freeze while the multi-cycle multiplier owns EX. Counts stalled cycles.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic [4:0]       IDEX_Rt,
  input  logic             IDEX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             EX_MulStart,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             MulBusy,
  output logic             MulDone,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MC_W = 4;

  typedef enum logic {RUN, MUL_BUSY} state_t;

  state_t           state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulBusy      = 1'b0;
    MulDone      = 1'b0;
    unique case (state_q)
      RUN: begin
        // Branch wins: anything behind it is wrong-path, so its hazards don't matter.
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
        end else if (EX_MulStart) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          EXMEM_Bubble = 1'b1;
          MulBusy      = 1'b1;
          mul_cnt_d    = MC_W'(MUL_LAT - 2);
          state_d      = MUL_BUSY;
        end else if (load_use) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        MulBusy = 1'b1;
        if (mul_cnt_q == '0) begin
          MulDone = 1'b1;
          state_d = RUN;
        end else begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          EXMEM_Bubble = 1'b1;
          mul_cnt_d    = mul_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    // Outputs must show their idle values for the whole time reset is held.
    if (!reset_n) begin
      PC_Write     = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Bubble  = 1'b0;
      EXMEM_Bubble = 1'b0;
      MulBusy      = 1'b0;
      MulDone      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

  a_flush_vs_hold: assert property (@(posedge clk) disable iff (!reset_n)
    !(IFID_Flush && !IFID_Write));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MUL_LAT=4, CNT_W=4 so saturation is reachable quickly).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, EX_MulStart;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, MulBusy, MulDone;
  logic [3:0] StallCount;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulStart(EX_MulStart),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
    .MulBusy(MulBusy), .MulDone(MulDone), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic idle();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
    IDEX_Rt = 5'd0; IDEX_MemRead = 1'b0;
    EX_BranchTaken = 1'b0; EX_MulStart = 1'b0;
  endtask

  task automatic lu2();  // lw $2 in ID/EX, consumer reads $2 via rs
    IDEX_Rt = 5'd2; IDEX_MemRead = 1'b1; IFID_Rs = 5'd2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // packed vector: {PC_Write,IFID_Write,IFID_Flush,IDEX_Bubble,EXMEM_Bubble,MulBusy,MulDone}
  function automatic logic [6:0] outs();
    return {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, MulBusy, MulDone};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle(); lu2(); EX_MulStart = 1'b1;
    #1;
    vectors++;
    if (outs() !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_outs got %b want %b", outs(), 7'b1100000);
    end
    tick();
    vectors++;
    if (StallCount !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", StallCount);
    end
    idle();
    reset_n = 1'b1;
    exp_cnt = 0;
    #1;
  endtask

  task automatic test_load_use();
    lu2(); #1;
    vectors++;
    if (outs() !== 7'b0001000) begin
      miscompares++;
      $display("FAIL lu_rs_outs got %b want %b", outs(), 7'b0001000);
    end
    tick(); exp_cnt++;
    idle(); #1;
    vectors++;
    if (StallCount !== 4'(exp_cnt) || outs() !== 7'b1100000) begin
      miscompares++;
      $display("FAIL lu_after cnt %0d want %0d outs %b want 1100000", StallCount, exp_cnt, outs());
    end
    // rt-side match when the consumer actually reads rt
    IDEX_Rt = 5'd7; IDEX_MemRead = 1'b1; IFID_Rs = 5'd3; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1; #1;
    vectors++;
    if (outs() !== 7'b0001000) begin
      miscompares++;
      $display("FAIL lu_rt_outs got %b want %b", outs(), 7'b0001000);
    end
    tick(); exp_cnt++;
    idle(); #1;
    vectors++;
    if (StallCount !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL lu_rt_count got %0d want %0d", StallCount, exp_cnt);
    end
  endtask

  task automatic test_no_false_stall();
    logic [4:0] idr [3];
    logic       mr  [3];
    logic [4:0] rs  [3];
    logic [4:0] rt  [3];
    logic       ur  [3];
    idr = '{5'd0, 5'd2, 5'd4};
    mr  = '{1'b1, 1'b1, 1'b0};
    rs  = '{5'd0, 5'd5, 5'd4};
    rt  = '{5'd0, 5'd2, 5'd4};
    ur  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      IDEX_Rt = idr[i]; IDEX_MemRead = mr[i]; IFID_Rs = rs[i]; IFID_Rt = rt[i]; IFID_UsesRt = ur[i];
      #1;
      vectors++;
      if (outs() !== 7'b1100000) begin
        miscompares++;
        $display("FAIL nofalse_%0d got %b want 1100000", i, outs());
      end
      tick();
    end
    idle(); #1;
    vectors++;
    if (StallCount !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL nofalse_count got %0d want %0d", StallCount, exp_cnt);
    end
  endtask

  task automatic test_branch();
    lu2(); EX_BranchTaken = 1'b1; #1;
    vectors++;
    if (outs() !== 7'b1111000) begin
      miscompares++;
      $display("FAIL br_lu got %b want 1111000", outs());
    end
    tick();
    EX_MulStart = 1'b1; #1;
    vectors++;
    if (outs() !== 7'b1111000) begin
      miscompares++;
      $display("FAIL br_mul got %b want 1111000", outs());
    end
    tick();
    idle(); #1;
    vectors++;
    if (StallCount !== 4'(exp_cnt) || outs() !== 7'b1100000) begin
      miscompares++;
      $display("FAIL br_after cnt %0d want %0d outs %b want 1100000", StallCount, exp_cnt, outs());
    end
  endtask

  task automatic test_mul();
    logic [6:0] exp_o [5];
    exp_o = '{7'b0000110, 7'b0000110, 7'b0000110, 7'b1100011, 7'b1100000};
    EX_MulStart = 1'b1; lu2();
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (outs() !== exp_o[c]) begin
        miscompares++;
        $display("FAIL mul_cyc%0d got %b want %b", c, outs(), exp_o[c]);
      end
      tick();
      // during the busy window the front-end inputs must be ignored
      idle(); EX_BranchTaken = (c < 2); lu2();
      if (c >= 3) idle();
    end
    exp_cnt += 3;
    vectors++;
    if (StallCount !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL mul_count got %0d want %0d", StallCount, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // a second multiply issued on the cycle right after MulDone
    EX_MulStart = 1'b1; tick(); idle(); tick(); tick();
    #1;
    vectors++;
    if (MulDone !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done1 got %b want 1", MulDone);
    end
    tick();
    EX_MulStart = 1'b1; #1;
    vectors++;
    if (outs() !== 7'b0000110) begin
      miscompares++;
      $display("FAIL b2b_start2 got %b want 0000110", outs());
    end
    tick(); idle(); tick(); tick(); #1;
    vectors++;
    if (MulDone !== 1'b1 || PC_Write !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done2 got done=%b pc=%b want 1 1", MulDone, PC_Write);
    end
    tick();
    exp_cnt += 6;
    vectors++;
    if (StallCount !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want %0d", StallCount, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    lu2();
    for (int i = 0; i < 20; i++) tick();
    idle(); #1;
    exp_cnt = (exp_cnt + 20 > 15) ? 15 : exp_cnt + 20;
    vectors++;
    if (StallCount !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL sat_count got %0d want %0d", StallCount, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_mul();
    int dones = 0;
    EX_MulStart = 1'b1; tick(); idle(); tick();  // now in second busy cycle
    reset_n = 1'b0; #1;
    vectors++;
    if (outs() !== 7'b1100000 || StallCount !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_mid got %b cnt %0d want 1100000 cnt 0", outs(), StallCount);
    end
    tick();
    reset_n = 1'b1; exp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (MulDone === 1'b1 || MulBusy === 1'b1 || PC_Write !== 1'b1) dones++;
      tick();
    end
    vectors++;
    if (dones != 0 || StallCount !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_after bad_cycles %0d want 0 cnt %0d want 0", dones, StallCount);
    end
  endtask

  initial begin
    idle();
    test_reset();
    tick();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_mul();
    test_back_to_back();
    test_saturation();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
